// File: rtl/b01_stream_sequencer_if.sv
// Operand and result valid/ready channels of the b01 stream sequencer.
// Ports: in_valid/in_ready/in_a/in_b (operand pair), res_valid/res_ready/res_data/res_ovf (result).
interface b01_stream_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/b01_stream_sequencer.sv
// Streams an operand pair LSB-first into the b01 core, collects outp into a result word.
// Ports: clock, reset, bus (operand/result handshakes), core_reset/line1/line2 out, core_outp/overflw in.
module b01_stream_sequencer #(
  parameter int WIDTH    = 8,
  parameter int CORE_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  b01_stream_sequencer_if.slave  bus,
  output logic                   core_reset,
  output logic                   core_line1,
  output logic                   core_line2,
  input  logic                   core_outp,
  input  logic                   core_overflw
);

  localparam int CW = $clog2(WIDTH + CORE_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             in_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;

  // cnt holds the cycle index since SHIFT cycle 0; the window
  // opens once the core latency has elapsed.
  logic capture;
  assign capture = ((state == SHIFT) || (state == DRAIN))
                && (cnt >= CW'(CORE_LAT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      cnt        <= '0;
      in_ready   <= 1'b0;
      core_reset <= 1'b1;
      core_line1 <= 1'b0;
      core_line2 <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          core_reset <= 1'b0;
          core_line1 <= 1'b0;
          core_line2 <= 1'b0;
          if (bus.in_valid && in_ready) begin
            a_sh       <= bus.in_a;
            b_sh       <= bus.in_b;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            cnt        <= '0;
            in_ready   <= 1'b0;
            core_reset <= 1'b1;
            state      <= CLR;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CLR: begin
          core_reset <= 1'b0;
          core_line1 <= a_sh[0];
          core_line2 <= b_sh[0];
          a_sh       <= a_sh >> 1;
          b_sh       <= b_sh >> 1;
          state      <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            core_line1 <= 1'b0;
            core_line2 <= 1'b0;
            state      <= DRAIN;
          end else begin
            core_line1 <= a_sh[0];
            core_line2 <= b_sh[0];
            a_sh       <= a_sh >> 1;
            b_sh       <= b_sh >> 1;
          end
        end
        DRAIN: begin
          cnt        <= cnt + 1'b1;
          core_line1 <= 1'b0;
          core_line2 <= 1'b0;
          if (cnt == CW'(WIDTH + CORE_LAT - 1)) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // in_ready rises with the handshake edge so it is first
          // seen high in the cycle after the result leaves.
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (capture) begin
        res_data <= {core_outp, res_data[WIDTH-1:1]};
        res_ovf  <= res_ovf | core_overflw;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_ovf   = res_ovf;

endmodule

// File: tb/tb_b01_stream_sequencer.sv
// Bench for b01_stream_sequencer with a loopback core stub.
// Ports: none; drives the operand/result interface and models the core.
module tb_b01_stream_sequencer;

  localparam int W   = 8;
  localparam int LAT = 1;

  logic clock = 1'b0;
  logic reset;
  logic core_reset;
  logic core_line1;
  logic core_line2;
  logic core_outp;
  logic core_overflw;
  logic sel;
  logic ovf_drv;
  logic dly;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  b01_stream_sequencer_if #(.WIDTH(W)) bus ();

  b01_stream_sequencer #(
    .WIDTH(W),
    .CORE_LAT(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .core_reset(core_reset),
    .core_line1(core_line1),
    .core_line2(core_line2),
    .core_outp(core_outp),
    .core_overflw(core_overflw)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Core stub: loop one line back after one cycle of latency.
  always @(posedge clock) dly <= sel ? core_line2 : core_line1;
  assign core_outp    = dly;
  assign core_overflw = ovf_drv;

  task automatic txn(input logic [7:0] a, input logic [7:0] b,
                     input logic s, input int slot, input int hold,
                     output int acc);
    int n;
    int lat;
    logic rdy;
    logic [7:0] l1;
    logic [7:0] l2;
    logic [7:0] exp_d;
    logic exp_o;
    exp_d = s ? b : a;
    exp_o = (slot >= 0) && (slot < W);
    sel = s;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      rdy = bus.in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!rdy && n < 60);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=%b want 1", rdy);
    end
    acc = cyc;
    bus.in_valid = 1'b0;
    bus.in_a = 8'($urandom);
    bus.in_b = 8'($urandom);
    l1 = '0;
    l2 = '0;
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clock);
      ovf_drv = (k == 2 + LAT + slot);
      if (k >= 2 && k - 2 < W) begin
        l1[k-2] = core_line1;
        l2[k-2] = core_line2;
      end
      @(posedge clock);
      #1;
      if (bus.res_valid === 1'b1) lat = k;
    end
    ovf_drv = 1'b0;
    checks++;
    if (lat !== W + LAT + 1) begin
      errors++;
      $display("FAIL latency got %0d want %0d", lat, W + LAT + 1);
    end
    checks++;
    if (l1 !== a) begin
      errors++;
      $display("FAIL line1_bits got %h want %h", l1, a);
    end
    checks++;
    if (l2 !== b) begin
      errors++;
      $display("FAIL line2_bits got %h want %h", l2, b);
    end
    checks++;
    if (bus.res_data !== exp_d) begin
      errors++;
      $display("FAIL res_data got %h want %h", bus.res_data, exp_d);
    end
    checks++;
    if (bus.res_ovf !== exp_o) begin
      errors++;
      $display("FAIL res_ovf got %b want %b (slot %0d)",
               bus.res_ovf, exp_o, slot);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_ready got %b want 0", bus.in_ready);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      checks++;
      if ({bus.res_valid, bus.in_ready, bus.res_data}
          !== {1'b1, 1'b0, exp_d}) begin
        errors++;
        $display("FAIL hold_stable got v=%b r=%b d=%h want v=1 r=0 d=%h",
                 bus.res_valid, bus.in_ready, bus.res_data, exp_d);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.res_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL handshake got v=%b r=%b want v=0 r=1",
               bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.in_ready, core_reset, core_line1, core_line2,
         bus.res_valid, bus.res_data, bus.res_ovf}
        !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got r=%b cr=%b l=%b%b v=%b d=%h o=%b",
               bus.in_ready, core_reset, core_line1, core_line2,
               bus.res_valid, bus.res_data, bus.res_ovf);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({bus.in_ready, core_reset} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release got r=%b cr=%b want r=1 cr=0",
               bus.in_ready, core_reset);
    end
  endtask

  task automatic test_loopback();
    int acc;
    txn(8'h5A, 8'h3C, 1'b0, -5, 0, acc);
    txn(8'h96, 8'hC3, 1'b1, -5, 0, acc);
  endtask

  task automatic test_overflow();
    int acc;
    txn(8'h12, 8'h34, 1'b0, 3, 0, acc);
    txn(8'h12, 8'h34, 1'b0, -1, 0, acc);
    txn(8'hA5, 8'h0F, 1'b1, W - 1, 0, acc);
    txn(8'hA5, 8'h0F, 1'b1, W, 0, acc);
  endtask

  task automatic test_hold();
    int acc;
    txn(8'h77, 8'h21, 1'b0, -5, 5, acc);
  endtask

  task automatic test_reset_mid();
    int acc;
    sel = 1'b0;
    bus.in_a = 8'h81;
    bus.in_b = 8'h18;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, core_reset, core_line1, core_line2,
         bus.res_valid, bus.res_data, bus.res_ovf}
        !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got r=%b cr=%b l=%b%b v=%b d=%h o=%b",
               bus.in_ready, core_reset, core_line1, core_line2,
               bus.res_valid, bus.res_data, bus.res_ovf);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({bus.in_ready, core_reset} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_release got r=%b cr=%b want r=1 cr=0",
               bus.in_ready, core_reset);
    end
    txn(8'hFF, 8'h00, 1'b0, -5, 0, acc);
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    txn(8'h3E, 8'hD1, 1'b0, -5, 0, acc1);
    txn(8'h6B, 8'h2C, 1'b1, 2, 0, acc2);
    checks++;
    if (acc2 - acc1 !== W + LAT + 3) begin
      errors++;
      $display("FAIL accept_spacing got %0d want %0d",
               acc2 - acc1, W + LAT + 3);
    end
  endtask

  task automatic test_random();
    int acc;
    for (int i = 0; i < 12; i++) begin
      txn(8'($urandom), 8'($urandom), 1'($urandom),
          $urandom_range(0, W + 3) - 2, $urandom_range(0, 3), acc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    sel = 1'b0;
    ovf_drv = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_loopback();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
